led_fader: RTL

Per-channel LED fade stage that sits directly downstream of `blink`: it consumes the 4-bit `led_out` on/off pattern and drives the board LEDs with a PWM signal whose duty cycle ramps smoothly up on each 0→1 transition and down on each 1→0 transition. Each of the four channels runs an independent fade state machine. A shared step prescaler and a shared PWM counter serve all four channels.

---
 rtl/led_fader.sv | 128 ++++++++++++
 1 files changed

// File: rtl/led_fader.sv
// Four-channel PWM fade stage: ramps LED duty up/down on each led_in edge.
// Define LED_FADE_SYNC_EN to pass led_in through a 2-flop synchroniser.
module led_fader #(
    parameter logic [31:0] CLK_FREQ = 32'd50_000_000,
    parameter logic [31:0] STEP_HZ  = 32'd1000,
    parameter int          PWM_BITS = 8
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic [3:0] led_in,
    output logic [3:0] led_out,
    output logic [3:0] busy
);

    localparam logic [31:0] P_RAW = CLK_FREQ / STEP_HZ;
    localparam logic [31:0] P     = (P_RAW == 32'd0) ? 32'd1 : P_RAW;
    localparam int          PRE_W = (P > 32'd1) ? $clog2(P) : 1;
    localparam logic [PRE_W-1:0]    PRE_LAST = PRE_W'(P - 32'd1);
    localparam logic [PWM_BITS-1:0] LVL_MAX  = '1;
    localparam logic [PWM_BITS-1:0] LVL_MIN  = '0;

    typedef enum logic [1:0] {
        ST_OFF,
        ST_RISE,
        ST_ON,
        ST_FALL
    } state_t;

    logic [PRE_W-1:0]    pre_cnt;
    logic                tick;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [3:0]          target;

    state_t              state    [4];
    state_t              state_nx [4];
    logic [PWM_BITS-1:0] level    [4];
    logic [PWM_BITS-1:0] level_nx [4];
    logic [PWM_BITS-1:0] level_up [4];
    logic [PWM_BITS-1:0] level_dn [4];

    assign tick = (pre_cnt == PRE_LAST);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            pre_cnt <= '0;
            pwm_cnt <= '0;
        end else begin
            pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
            pwm_cnt <= pwm_cnt + 1'b1;
        end
    end

`ifdef LED_FADE_SYNC_EN
    logic [3:0] sync_a;
    logic [3:0] sync_b;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync_a <= '0;
            sync_b <= '0;
        end else begin
            sync_a <= led_in;
            sync_b <= sync_a;
        end
    end

    assign target = sync_b;
`else
    assign target = led_in;
`endif

    // A reversal on a tick cycle takes that tick's step in the new direction;
    // the terminal-state check only applies when continuing in the same direction.
    always_comb begin
        for (int unsigned i = 0; i < 4; i++) begin
            state_nx[i] = state[i];
            level_nx[i] = level[i];
            level_up[i] = (level[i] == LVL_MAX) ? level[i] : level[i] + 1'b1;
            level_dn[i] = (level[i] == LVL_MIN) ? level[i] : level[i] - 1'b1;
            case (state[i])
                ST_OFF: begin
                    if (target[i]) state_nx[i] = ST_RISE;
                end
                ST_RISE: begin
                    if (!target[i]) begin
                        state_nx[i] = ST_FALL;
                        if (tick) level_nx[i] = level_dn[i];
                    end else if (tick) begin
                        level_nx[i] = level_up[i];
                        if (level_up[i] == LVL_MAX) state_nx[i] = ST_ON;
                    end
                end
                ST_ON: begin
                    if (!target[i]) state_nx[i] = ST_FALL;
                end
                ST_FALL: begin
                    if (target[i]) begin
                        state_nx[i] = ST_RISE;
                        if (tick) level_nx[i] = level_up[i];
                    end else if (tick) begin
                        level_nx[i] = level_dn[i];
                        if (level_dn[i] == LVL_MIN) state_nx[i] = ST_OFF;
                    end
                end
                default: state_nx[i] = ST_OFF;
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            for (int unsigned i = 0; i < 4; i++) begin
                state[i] <= ST_OFF;
                level[i] <= '0;
            end
            led_out <= '0;
            busy    <= '0;
        end else begin
            for (int unsigned i = 0; i < 4; i++) begin
                state[i]   <= state_nx[i];
                level[i]   <= level_nx[i];
                led_out[i] <= (state[i] == ST_ON) || (pwm_cnt < level[i]);
                busy[i]    <= (state_nx[i] == ST_RISE) || (state_nx[i] == ST_FALL);
            end
        end
    end

endmodule
